ram_scan_ctrl: RTL and testbench

Sequencing controller for the 32x4 dual-port RAM lab datapath. It turns the write pushbutton into exactly one registered write strobe per debounced press, latching address and data from the switches at the time of the press. It also drives the read port with a free-running read address that steps through all 32 words at a fixed rate and can be frozen. Its outputs feed the RAM ports and the HEX display block.

---
 rtl/ram_scan_ctrl.sv | 104 ++++++++++
 tb/tb_ram_scan_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_ctrl.sv
// rtl/ram_scan_ctrl.sv - write-strobe sequencer and free-running read scan for the 32x4 dual-port RAM lab
`timescale 1ns/1ps
module ram_scan_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DEBOUNCE = 500_000,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_wr,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              hold,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic          key_meta;
  logic          key_s;
  logic [1:0]    state;
  logic [DW-1:0] deb_cnt;
  logic [PW-1:0] pre;

  // Synchronizer resets to "pressed" so a key held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      key_meta <= 1'b0;
      key_s    <= 1'b0;
    end else begin
      key_meta <= key_wr;
      key_s    <= key_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_RELEASE;
      deb_cnt   <= '0;
      wren      <= 1'b0;
      wraddress <= '0;
      data      <= '0;
    end else begin
      wren <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!key_s) begin
            state     <= S_WRITE;
            wren      <= 1'b1;
            wraddress <= sw_addr;
            data      <= sw_data;
          end
        end
        S_WRITE: begin
          state   <= S_RELEASE;
          deb_cnt <= '0;
        end
        S_RELEASE: begin
          // Any bounce back to pressed restarts the release interval.
          if (!key_s) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_MAX) begin
            state   <= S_IDLE;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DW'(1);
          end
        end
        default: state <= S_RELEASE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre       <= '0;
      rdaddress <= '0;
      tick      <= 1'b0;
    end else if (hold) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre       <= '0;
      rdaddress <= rdaddress + ADDR_W'(1);
      tick      <= 1'b1;
    end else begin
      pre  <= pre + PW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// tb/tb_ram_scan_ctrl.sv - directed bench for ram_scan_ctrl with TICK_DIV=4, DEBOUNCE=3
`timescale 1ns/1ps
module tb_ram_scan_ctrl;

  logic       clk;
  logic       reset_n;
  logic       key_wr;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic       hold;
  logic       wren;
  logic [4:0] wraddress;
  logic [3:0] data;
  logic [4:0] rdaddress;
  logic       tick;

  int errors;
  int checks;
  int n;
  int wren_cnt;
  int tick_cnt;
  int tick_base;
  bit scan_chk;

  ram_scan_ctrl #(.TICK_DIV(4), .DEBOUNCE(3), .ADDR_W(5), .DATA_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .key_wr(key_wr), .sw_addr(sw_addr),
    .sw_data(sw_data), .hold(hold), .wren(wren), .wraddress(wraddress),
    .data(data), .rdaddress(rdaddress), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wren_cnt = 0;
    tick_cnt = 0;
  end
  always @(negedge clk) begin
    if (wren === 1'b1) wren_cnt++;
    if (tick === 1'b1) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n counts edges since reset was released; scan expectations follow from it.
  task automatic step();
    @(posedge clk);
    if (!reset_n) n = 0;
    else n++;
    #1;
    if (scan_chk && n > 0) begin
      check("scan_rd", rdaddress, (n / 4) % 32);
      check("scan_tick", tick, (n % 4) == 0);
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; n = 0; scan_chk = 0;
    reset_n = 1'b0; key_wr = 1'b1; hold = 1'b0; sw_addr = '0; sw_data = '0;

    step();
    check("rst1_wren", wren, 0);
    step(); step();
    check("rst_wren", wren, 0);
    check("rst_wraddr", wraddress, 0);
    check("rst_data", data, 0);
    check("rst_rdaddr", rdaddress, 0);
    check("rst_tick", tick, 0);

    reset_n = 1'b1;
    tick_base = tick_cnt;
    scan_chk = 1;
    run_to(5);
    check("no_wren_after_reset", wren_cnt, 0);

    // single write
    sw_addr = 5'h13; sw_data = 4'hA; key_wr = 1'b0;
    step(); check("wr_lat_e1", wren, 0);
    step(); check("wr_lat_e2", wren, 0);
    step();
    check("wr_pulse", wren, 1);
    check("wr_addr", wraddress, 5'h13);
    check("wr_data", data, 4'hA);
    step();
    check("wr_one_cycle", wren, 0);
    sw_addr = 5'h04; sw_data = 4'h5;
    run_to(15);
    check("wr_addr_held", wraddress, 5'h13);
    check("wr_data_held", data, 4'hA);
    check("wr_single", wren_cnt, 1);
    key_wr = 1'b1;

    // bounce: FSM back in IDLE at edge 20
    run_to(20);
    for (int i = 0; i < 8; i++) begin
      key_wr = (i % 2 == 1);
      step();
    end
    check("bounce_one_wren", wren_cnt, 2);
    check("bounce_addr", wraddress, 5'h04);
    run_to(29);
    key_wr = 1'b0;
    run_to(35);
    check("early_press_ignored", wren_cnt, 2);
    key_wr = 1'b1;

    // press timed so wren coincides with tick at edge 44, write to rdaddress 11
    run_to(41);
    sw_addr = 5'd11; sw_data = 4'h3; key_wr = 1'b0;
    step();
    key_wr = 1'b1;
    run_to(44);
    check("sim_wren", wren, 1);
    check("sim_tick", tick, 1);
    check("sim_rdaddr", rdaddress, 11);
    check("sim_wraddr", wraddress, 11);
    check("sim_data", data, 4'h3);
    step();
    check("sim_wren_end", wren, 0);
    check("sim_wren_cnt", wren_cnt, 3);

    // scan wrap
    run_to(124);
    check("wrap_31", rdaddress, 31);
    run_to(128);
    check("wrap_0", rdaddress, 0);
    check("wrap_tick", tick, 1);
    run_to(132);
    check("scan_132_rd", rdaddress, 1);
    step();
    check("tick_count_132", tick_cnt - tick_base, 33);
    check("no_stray_wren", wren_cnt, 3);
    scan_chk = 0;

    // reset mid-scan
    reset_n = 1'b0;
    step();
    check("rst2_rdaddr", rdaddress, 0);
    check("rst2_tick", tick, 0);
    check("rst2_wraddr", wraddress, 0);
    check("rst2_data", data, 0);
    reset_n = 1'b1;
    scan_chk = 1;
    run_to(30);
    scan_chk = 0;
    check("hold_start_rd", rdaddress, 7);

    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("hold_rd", rdaddress, 7);
      check("hold_tick", tick, 0);
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("unhold_wait_tick", tick, 0);
      check("unhold_wait_rd", rdaddress, 7);
    end
    step();
    check("unhold_tick", tick, 1);
    check("unhold_rd", rdaddress, 8);
    step();
    check("unhold_tick_end", tick, 0);
    check("no_wren_phase2", wren_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
